// File: rtl/alu_seq.sv
// alu_seq: valid/ready sequencer around the 16-bit alu; iterates single-bit shifts
// and returns a registered result with carry/zero flags.
module alu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_cnt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic [15:0] work_a_q, work_a_d, b_q, b_d, res_q, res_d;
    logic [3:0]  op_q, op_d, cnt_q, cnt_d;
    logic        carry_q, carry_d, zero_q, zero_d;
    logic        is_shift;

    assign is_shift = (req_op == 4'b0101) || (req_op == 4'b0110);

    always_comb begin
        state_d  = state_q;
        work_a_d = work_a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: if (req_valid) begin
                // zero-count shifts bypass the ALU, leaving its operand registers untouched
                if (is_shift && req_cnt == 4'd0) begin
                    res_d   = req_a;
                    carry_d = 1'b0;
                    zero_d  = (req_a == 16'd0);
                    state_d = RESP;
                end else begin
                    work_a_d = req_a;
                    b_d      = req_b;
                    op_d     = req_op;
                    cnt_d    = is_shift ? req_cnt : 4'd1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                work_a_d = alu_result;
                cnt_d    = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    res_d   = alu_result;
                    carry_d = alu_carry;
                    zero_d  = alu_zero;
                    state_d = RESP;
                end
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_a_q <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_a_q <= work_a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;
    assign alu_a      = work_a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a whole-operation
// reference model, with a behavioural alu attached to the ALU ports.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [3:0]  req_cnt = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        alu_zero;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0]  e_op, e_cnt;
    logic [15:0] e_a, e_b, e_res;
    logic        e_c, e_z;
    int          e_lat;

    alu_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    // stand-in for the combinational alu
    always_comb begin
        alu_carry  = 1'b0;
        alu_result = '0;
        case (alu_op)
            4'd0: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a | alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = alu_a << 1;
            4'd6: alu_result = alu_a >> 1;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 16'd0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] cnt);
        logic [16:0] sum;
        logic        ok;
        int          n;
        e_op = op; e_a = a; e_b = b; e_cnt = cnt; e_c = 1'b0;
        e_lat = (op == 4'd5 || op == 4'd6) ? int'(cnt) : 1;
        sum = {1'b0, a} + {1'b0, b};
        case (op)
            4'd0: {e_c, e_res} = sum;
            4'd1: e_res = a - b;
            4'd2: e_res = a & b;
            4'd3: e_res = a | b;
            4'd4: e_res = a ^ b;
            4'd5: e_res = a << cnt;
            4'd6: e_res = a >> cnt;
            default: e_res = '0;
        endcase
        e_z = (e_res == 16'd0);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cnt = cnt;
        n = 0;
        do begin
            ok = req_ready;
            @(posedge clk);
            n++;
        end while (!ok && n < 40);
        #1 req_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic collect(input int hold);
        int          k;
        logic [15:0] ea;
        k = 0;
        while (!rsp_valid && k < 40) begin
            ea = (e_op == 4'd5) ? e_a << k : (e_op == 4'd6) ? e_a >> k : e_a;
            check("alu_a", alu_a, ea);
            check("alu_b", alu_b, e_b);
            check("alu_op", alu_op, e_op);
            @(posedge clk);
            #1 k++;
        end
        check("latency", k, e_lat);
        check("result", rsp_result, e_res);
        check("carry", rsp_carry, e_c);
        check("zero", rsp_zero, e_z);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_ready", req_ready, 0);
            check("hold_result", rsp_result, e_res);
        end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("done_valid", rsp_valid, 0);
        check("done_ready", req_ready, 1);
    endtask

    initial begin
        int seen;
        #12;
        check("rst_ready", req_ready, 1);
        check("rst_valid", rsp_valid, 0);
        check("rst_result", rsp_result, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_op", alu_op, 0);
        @(negedge clk) rst_n = 1'b1;

        issue(4'd6, 16'h0000, 16'h1234, 4'd0);
        collect(0);
        check("cnt0_alu_op", alu_op, 0);

        issue(4'd0, 16'hFFFF, 16'h0001, 4'd0);
        collect(0);
        issue(4'd1, 16'h0005, 16'h0007, 4'd0);
        collect(1);
        issue(4'd5, 16'h0001, 16'h0000, 4'd15);
        collect(0);
        issue(4'd9, 16'hABCD, 16'h1111, 4'd3);
        collect(0);

        // backpressure with a second request waiting
        issue(4'd4, 16'h00FF, 16'h0F0F, 4'd0);
        req_valid = 1'b1; req_op = 4'd2; req_a = 16'hF0F0; req_b = 16'h3C3C; req_cnt = 4'd0;
        collect(5);
        issue(4'd2, 16'hF0F0, 16'h3C3C, 4'd0);
        collect(0);

        // asynchronous reset in the third EXEC cycle of an 8-step shift
        issue(4'd5, 16'h0003, 16'h0000, 4'd8);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_alu_a", alu_a, 0);
        check("arst_alu_op", alu_op, 0);
        check("arst_valid", rsp_valid, 0);
        check("arst_result", rsp_result, 0);
        check("arst_ready", req_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("arst_no_rsp", seen, 0);

        for (int i = 0; i < 40; i++) begin
            issue(4'($urandom_range(0, 8)), 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
            collect(int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
